// File: rtl/rename_pkg.sv
// Rename-stage constants and index type shared by the free list, RAT and RRAT.
package rename_pkg;

    localparam int PRF_SIZE  = 64;
    localparam int ARF_SIZE  = 32;
    localparam int PRF_IDX_W = $clog2(PRF_SIZE);

    typedef logic [PRF_IDX_W-1:0] prf_idx_t;

endpackage : rename_pkg

// File: rtl/prf_pick_two.sv
// Combinational encoder returning the lowest and second-lowest set bits of a vector.
module prf_pick_two #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx1_o,
    output logic [W-1:0] idx2_o,
    output logic         found1_o,
    output logic         found2_o
);

    logic [N-1:0] rest;

    // Scanning downward lets the lowest set bit be the last assignment to stick.
    always_comb begin
        found1_o = 1'b0;
        idx1_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found1_o = 1'b1;
                idx1_o   = W'(i);
            end
        end
    end

    always_comb begin
        rest = vec_i;
        if (found1_o) begin
            rest[idx1_o] = 1'b0;
        end
        found2_o = 1'b0;
        idx2_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rest[i]) begin
                found2_o = 1'b1;
                idx2_o   = W'(i);
            end
        end
    end

endmodule : prf_pick_two

// File: rtl/prf_free_list.sv
// Physical register free list offering two lowest free entries per cycle to the rename RAT.
module prf_free_list
    import rename_pkg::*;
#(
    parameter int PRF_SIZE  = rename_pkg::PRF_SIZE,
    parameter int PRF_IDX_W = $clog2(PRF_SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 request1,
    input  logic                 request2,
    input  logic                 PRF_free_valid,
    input  logic [PRF_SIZE-1:0]  PRF_free_list_out,
    input  logic                 retire_free_valid1,
    input  logic [PRF_IDX_W-1:0] retire_free_idx1,
    input  logic                 retire_free_valid2,
    input  logic [PRF_IDX_W-1:0] retire_free_idx2,
    output logic                 PRF_rename_valid1,
    output logic [PRF_IDX_W-1:0] PRF_rename_idx1,
    output logic                 PRF_rename_valid2,
    output logic [PRF_IDX_W-1:0] PRF_rename_idx2,
    output logic [PRF_IDX_W:0]   free_count,
    output logic                 free_list_full
);

    logic [PRF_SIZE-1:0]  free_vec_q;
    logic [PRF_SIZE-1:0]  free_vec_d;
    logic [PRF_SIZE-1:0]  alloc_mask;
    logic [PRF_SIZE-1:0]  release_mask;
    logic [PRF_IDX_W-1:0] pick_idx1;
    logic [PRF_IDX_W-1:0] pick_idx2;
    logic                 pick_found1;
    logic                 pick_found2;

    prf_pick_two #(
        .N (PRF_SIZE),
        .W (PRF_IDX_W)
    ) u_pick (
        .vec_i    (free_vec_q),
        .idx1_o   (pick_idx1),
        .idx2_o   (pick_idx2),
        .found1_o (pick_found1),
        .found2_o (pick_found2)
    );

    // Offers depend only on registered state, so there is no path back into the RAT.
    assign PRF_rename_valid1 = pick_found1;
    assign PRF_rename_valid2 = pick_found2;
    assign PRF_rename_idx1   = pick_found1 ? pick_idx1 : '0;
    assign PRF_rename_idx2   = pick_found2 ? pick_idx2 : '0;
    assign free_list_full    = &free_vec_q;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < PRF_SIZE; i++) begin
            free_count = free_count + {{PRF_IDX_W{1'b0}}, free_vec_q[i]};
        end
    end

    // A mispredict flush cancels both allocations in the same cycle.
    always_comb begin
        alloc_mask = '0;
        if (request1 && pick_found1 && !PRF_free_valid) begin
            alloc_mask[pick_idx1] = 1'b1;
        end
        if (request2 && pick_found2 && !PRF_free_valid) begin
            alloc_mask[pick_idx2] = 1'b1;
        end
    end

    always_comb begin
        release_mask = PRF_free_valid ? PRF_free_list_out : '0;
        if (retire_free_valid1) begin
            release_mask[retire_free_idx1] = 1'b1;
        end
        if (retire_free_valid2) begin
            release_mask[retire_free_idx2] = 1'b1;
        end
    end

    // Frees are ORed in last so they win over an allocation of the same entry.
    assign free_vec_d = (free_vec_q & ~alloc_mask) | release_mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_vec_q <= '1;
        end else begin
            free_vec_q <= free_vec_d;
        end
    end

endmodule : prf_free_list

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list with hand-computed expectations per scenario.
module tb_prf_free_list;

    logic        clock;
    logic        reset;
    logic        request1;
    logic        request2;
    logic        PRF_free_valid;
    logic [63:0] PRF_free_list_out;
    logic        retire_free_valid1;
    logic [5:0]  retire_free_idx1;
    logic        retire_free_valid2;
    logic [5:0]  retire_free_idx2;
    logic        PRF_rename_valid1;
    logic [5:0]  PRF_rename_idx1;
    logic        PRF_rename_valid2;
    logic [5:0]  PRF_rename_idx2;
    logic [6:0]  free_count;
    logic        free_list_full;

    int n_cmp;
    int n_err;

    prf_free_list dut (
        .clock              (clock),
        .reset              (reset),
        .request1           (request1),
        .request2           (request2),
        .PRF_free_valid     (PRF_free_valid),
        .PRF_free_list_out  (PRF_free_list_out),
        .retire_free_valid1 (retire_free_valid1),
        .retire_free_idx1   (retire_free_idx1),
        .retire_free_valid2 (retire_free_valid2),
        .retire_free_idx2   (retire_free_idx2),
        .PRF_rename_valid1  (PRF_rename_valid1),
        .PRF_rename_idx1    (PRF_rename_idx1),
        .PRF_rename_valid2  (PRF_rename_valid2),
        .PRF_rename_idx2    (PRF_rename_idx2),
        .free_count         (free_count),
        .free_list_full     (free_list_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        request1           = 1'b0;
        request2           = 1'b0;
        PRF_free_valid     = 1'b0;
        PRF_free_list_out  = '0;
        retire_free_valid1 = 1'b0;
        retire_free_idx1   = '0;
        retire_free_valid2 = 1'b0;
        retire_free_idx2   = '0;
    endtask

    // Apply current inputs across one rising edge, then clear them 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (PRF_rename_valid1 !== 1'b1) begin n_err++; $display("FAIL reset_valid1 got=%0b exp=1", PRF_rename_valid1); end
        n_cmp++; if (PRF_rename_valid2 !== 1'b1) begin n_err++; $display("FAIL reset_valid2 got=%0b exp=1", PRF_rename_valid2); end
        n_cmp++; if (PRF_rename_idx1 !== 6'd0) begin n_err++; $display("FAIL reset_idx1 got=%0d exp=0", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd1) begin n_err++; $display("FAIL reset_idx2 got=%0d exp=1", PRF_rename_idx2); end
        n_cmp++; if (free_count !== 7'd64) begin n_err++; $display("FAIL reset_count got=%0d exp=64", free_count); end
        n_cmp++; if (free_list_full !== 1'b1) begin n_err++; $display("FAIL reset_full got=%0b exp=1", free_list_full); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_alloc_pair();
        request1 = 1'b1; request2 = 1'b1;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd2) begin n_err++; $display("FAIL pair_idx1 got=%0d exp=2", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd3) begin n_err++; $display("FAIL pair_idx2 got=%0d exp=3", PRF_rename_idx2); end
        n_cmp++; if (free_count !== 7'd62) begin n_err++; $display("FAIL pair_count got=%0d exp=62", free_count); end
        n_cmp++; if (free_list_full !== 1'b0) begin n_err++; $display("FAIL pair_full got=%0b exp=0", free_list_full); end
        request2 = 1'b1;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd2) begin n_err++; $display("FAIL slot2_idx1 got=%0d exp=2", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd4) begin n_err++; $display("FAIL slot2_idx2 got=%0d exp=4", PRF_rename_idx2); end
        n_cmp++; if (free_count !== 7'd61) begin n_err++; $display("FAIL slot2_count got=%0d exp=61", free_count); end
    endtask

    // Brings the allocation total to 10, then asserts reset between clock edges.
    task automatic test_reset_mid();
        repeat (3) begin
            request1 = 1'b1; request2 = 1'b1;
            step();
        end
        request1 = 1'b1;
        step();
        n_cmp++; if (free_count !== 7'd54) begin n_err++; $display("FAIL mid_count_pre got=%0d exp=54", free_count); end
        n_cmp++; if (PRF_rename_idx1 !== 6'd10) begin n_err++; $display("FAIL mid_idx1_pre got=%0d exp=10", PRF_rename_idx1); end
        #1;
        request1 = 1'b1; request2 = 1'b1;
        reset = 1'b1;
        #1;
        n_cmp++; if (free_count !== 7'd64) begin n_err++; $display("FAIL mid_count got=%0d exp=64", free_count); end
        n_cmp++; if (PRF_rename_idx1 !== 6'd0) begin n_err++; $display("FAIL mid_idx1 got=%0d exp=0", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd1) begin n_err++; $display("FAIL mid_idx2 got=%0d exp=1", PRF_rename_idx2); end
        n_cmp++; if ({PRF_rename_valid1, PRF_rename_valid2, free_list_full} !== 3'b111) begin n_err++; $display("FAIL mid_flags got=%03b exp=111", {PRF_rename_valid1, PRF_rename_valid2, free_list_full}); end
        @(posedge clock);
        #2;
        reset = 1'b0;
        clear_inputs();
        step();
        n_cmp++; if (free_count !== 7'd64) begin n_err++; $display("FAIL mid_count_post got=%0d exp=64", free_count); end
    endtask

    task automatic test_exhaust();
        repeat (31) begin
            request1 = 1'b1; request2 = 1'b1;
            step();
        end
        n_cmp++; if (free_count !== 7'd2) begin n_err++; $display("FAIL ex62_count got=%0d exp=2", free_count); end
        n_cmp++; if (PRF_rename_idx1 !== 6'd62) begin n_err++; $display("FAIL ex62_idx1 got=%0d exp=62", PRF_rename_idx1); end
        request1 = 1'b1;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd63) begin n_err++; $display("FAIL ex63_idx1 got=%0d exp=63", PRF_rename_idx1); end
        n_cmp++; if ({PRF_rename_valid1, PRF_rename_valid2} !== 2'b10) begin n_err++; $display("FAIL ex63_valids got=%02b exp=10", {PRF_rename_valid1, PRF_rename_valid2}); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd0) begin n_err++; $display("FAIL ex63_idx2 got=%0d exp=0", PRF_rename_idx2); end
        n_cmp++; if (free_count !== 7'd1) begin n_err++; $display("FAIL ex63_count got=%0d exp=1", free_count); end
        request1 = 1'b1; request2 = 1'b1;
        step();
        n_cmp++; if ({PRF_rename_valid1, PRF_rename_valid2} !== 2'b00) begin n_err++; $display("FAIL empty_valids got=%02b exp=00", {PRF_rename_valid1, PRF_rename_valid2}); end
        n_cmp++; if (PRF_rename_idx1 !== 6'd0) begin n_err++; $display("FAIL empty_idx1 got=%0d exp=0", PRF_rename_idx1); end
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL empty_count got=%0d exp=0", free_count); end
        request1 = 1'b1; request2 = 1'b1;
        step();
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL empty_req_count got=%0d exp=0", free_count); end
        n_cmp++; if (PRF_rename_valid1 !== 1'b0) begin n_err++; $display("FAIL empty_req_valid1 got=%0b exp=0", PRF_rename_valid1); end
    endtask

    task automatic test_retire();
        retire_free_valid1 = 1'b1; retire_free_idx1 = 6'd9;
        retire_free_valid2 = 1'b1; retire_free_idx2 = 6'd5;
        #1;
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL retire_nobypass got=%0d exp=0", free_count); end
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd5) begin n_err++; $display("FAIL retire_idx1 got=%0d exp=5", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd9) begin n_err++; $display("FAIL retire_idx2 got=%0d exp=9", PRF_rename_idx2); end
        n_cmp++; if (free_count !== 7'd2) begin n_err++; $display("FAIL retire_count got=%0d exp=2", free_count); end
        request1 = 1'b1; request2 = 1'b1;
        step();
        retire_free_valid1 = 1'b1; retire_free_idx1 = 6'd20;
        retire_free_valid2 = 1'b1; retire_free_idx2 = 6'd20;
        step();
        n_cmp++; if (free_count !== 7'd1) begin n_err++; $display("FAIL dup_count got=%0d exp=1", free_count); end
        n_cmp++; if (PRF_rename_idx1 !== 6'd20) begin n_err++; $display("FAIL dup_idx1 got=%0d exp=20", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_valid2 !== 1'b0) begin n_err++; $display("FAIL dup_valid2 got=%0b exp=0", PRF_rename_valid2); end
        request1 = 1'b1;
        step();
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL dup_realloc got=%0d exp=0", free_count); end
    endtask

    task automatic test_mispredict();
        logic [63:0] m;
        m = '0; m[10] = 1'b1; m[12] = 1'b1;
        PRF_free_valid = 1'b1; PRF_free_list_out = m;
        request1 = 1'b1;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd10) begin n_err++; $display("FAIL mp_idx1 got=%0d exp=10", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd12) begin n_err++; $display("FAIL mp_idx2 got=%0d exp=12", PRF_rename_idx2); end
        n_cmp++; if (free_count !== 7'd2) begin n_err++; $display("FAIL mp_count got=%0d exp=2", free_count); end
    endtask

    task automatic test_free_override();
        logic [63:0] m;
        retire_free_valid1 = 1'b1; retire_free_idx1 = 6'd7;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd7) begin n_err++; $display("FAIL ovr_setup_idx1 got=%0d exp=7", PRF_rename_idx1); end
        n_cmp++; if (free_count !== 7'd3) begin n_err++; $display("FAIL ovr_setup_count got=%0d exp=3", free_count); end
        request1 = 1'b1;
        retire_free_valid1 = 1'b1; retire_free_idx1 = 6'd7;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd7) begin n_err++; $display("FAIL ovr_idx1 got=%0d exp=7", PRF_rename_idx1); end
        n_cmp++; if (free_count !== 7'd3) begin n_err++; $display("FAIL ovr_count got=%0d exp=3", free_count); end
        m = '0; m[30] = 1'b1;
        PRF_free_valid = 1'b1; PRF_free_list_out = m;
        retire_free_valid2 = 1'b1; retire_free_idx2 = 6'd40;
        request2 = 1'b1;
        step();
        n_cmp++; if (free_count !== 7'd5) begin n_err++; $display("FAIL mp_retire_count got=%0d exp=5", free_count); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd10) begin n_err++; $display("FAIL mp_retire_idx2 got=%0d exp=10", PRF_rename_idx2); end
    endtask

    task automatic test_back_to_back();
        request1 = 1'b1; request2 = 1'b1;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd12) begin n_err++; $display("FAIL b2b1_idx1 got=%0d exp=12", PRF_rename_idx1); end
        n_cmp++; if (PRF_rename_idx2 !== 6'd30) begin n_err++; $display("FAIL b2b1_idx2 got=%0d exp=30", PRF_rename_idx2); end
        request1 = 1'b1; request2 = 1'b1;
        step();
        n_cmp++; if (PRF_rename_idx1 !== 6'd40) begin n_err++; $display("FAIL b2b2_idx1 got=%0d exp=40", PRF_rename_idx1); end
        n_cmp++; if ({PRF_rename_valid1, PRF_rename_valid2} !== 2'b10) begin n_err++; $display("FAIL b2b2_valids got=%02b exp=10", {PRF_rename_valid1, PRF_rename_valid2}); end
        n_cmp++; if (free_count !== 7'd1) begin n_err++; $display("FAIL b2b2_count got=%0d exp=1", free_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_alloc_pair();
        test_reset_mid();
        test_exhaust();
        test_retire();
        test_mispredict();
        test_free_override();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prf_free_list
